bank_context_stack: RTL and testbench
=====================================

Name: bank_context_stack

Overview:
Parametrised successor to the core's two-context register-bank selector. It tracks a bank number for each of DEPTH interrupt-nesting levels: level 0 is normal execution, and levels 1..DEPTH-1 are nested interrupt handlers. It drives the current bank to the ALU and output-select logic. It replaces the single normal/interrupt pair with a bounded context stack, sticky overflow and underflow flags, and a tail-chain case.

Parameters:
BANK_W, 2, width of a bank number
DEPTH, 4, number of context levels including level 0 (minimum 2)
LVL_W, 2, width of the level counter; must satisfy 2^LVL_W >= DEPTH
IRQ_BANK, 0, bank value loaded into a level's entry when that level is entered
RST_BANK, 0, reset value of every level's entry

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous reset, active-high
sBank  in  1  write sAddrBank into the current level's entry
sAddrBank  in  BANK_W  new bank value for the current level
irq_enter  in  1  one-cycle pulse; an interrupt is accepted, push a level
irq_exit  in  1  one-cycle pulse; return from interrupt, pop a level
clr  in  1  clear the sticky error flags
bank  out  BANK_W  bank of the current level (combinational from registers)
level  out  LVL_W  current nesting level
inter  out  1  high when level != 0
full  out  1  high when level == DEPTH-1
ovf  out  1  sticky flag: irq_enter arrived while full
unf  out  1  sticky flag: irq_exit arrived at level 0

Behaviour:
- Reset (async, rst=1):
  - level=0
  - all entries=RST_BANK, so bank=RST_BANK
  - inter=0, full=0 (DEPTH>1), ovf=0, unf=0
- State: entry array bank_reg[0..DEPTH-1] of width BANK_W, and level counter lvl.
- bank = bank_reg[lvl]. Every change appears the cycle after the causing edge; there is no extra pipeline stage.
- Event priority each cycle, by case:
  - Enter only, lvl<DEPTH-1: lvl<=lvl+1; bank_reg[lvl+1]<=IRQ_BANK. If sBank=1 in the same cycle, bank_reg[lvl+1]<=sAddrBank instead (the write targets the new level).
  - Enter only, lvl==DEPTH-1: level and entries unchanged; ovf<=1. A sBank in that cycle writes bank_reg[lvl] normally.
  - Exit only, lvl>0: lvl<=lvl-1. The popped entry is not cleared. The caller's entry bank_reg[lvl-1] is restored unchanged. A sBank in that cycle is discarded.
  - Exit only, lvl==0: no change; unf<=1. A sBank in that cycle writes bank_reg[0].
  - Enter and exit together (tail-chain): lvl unchanged; bank_reg[lvl]<=IRQ_BANK, or sAddrBank if sBank=1. At lvl==0 this counts as exit-at-0 then enter: lvl<=1, unf<=1.
  - sBank alone: bank_reg[lvl]<=sAddrBank.
- Sticky flags:
  - clr=1 clears ovf and unf.
  - A set condition in the same cycle as clr wins (flag=1).
- Outputs: full = (lvl==DEPTH-1); inter = (lvl!=0).
- Entries above lvl hold stale data and are never observable on bank.
- Reset asserted mid-sequence returns to the reset state immediately, regardless of clk.

Optional Feature:
- Macro: BANK_INHERIT_EN.
- Defined: on a successful enter or tail-chain, the new entry is loaded with the caller's current bank_reg[lvl] instead of IRQ_BANK. An explicit sBank in the same cycle still overrides.
- Undefined: the new entry is loaded with IRQ_BANK as described above.

Test Plan:
- Reset, then sBank=1 with sAddrBank=3 -> next cycle bank=3, level=0, inter=0.
- From level 0 with bank=3: pulse irq_enter -> level=1, inter=1, bank=0 (bank=3 with BANK_INHERIT_EN). Then sBank with value 2 -> bank=2. Then pulse irq_exit -> level=0, bank=3.
- Four enters with DEPTH=4 -> level reaches 3, full=1, and the 4th enter sets ovf=1 with level still 3. Then clr=1 -> ovf=0. A clr and an overflowing enter in the same cycle -> ovf=1.
- irq_exit at level 0 -> unf=1, level=0, bank unchanged. Enter and exit together at level 2 with sBank value 1 -> level=2, bank=1.
- Enter in the same cycle as sBank value 2 at level 0 -> level=1, bank=2, and bank_reg[0] is unchanged (verified after exit).
- Assert rst asynchronously mid-cycle at level 2 -> level=0, bank=RST_BANK, ovf=0, unf=0 before the next clk edge.

Source files
------------

// File: rtl/bank_context_stack_if.sv
// bank_context_stack_if: control inputs and bank/level/status outputs of the bank context stack
interface bank_context_stack_if #(
    parameter int BANK_W = 2,
    parameter int LVL_W  = 2
);
    logic              sBank;
    logic [BANK_W-1:0] sAddrBank;
    logic              irq_enter;
    logic              irq_exit;
    logic              clr;
    logic [BANK_W-1:0] bank;
    logic [LVL_W-1:0]  level;
    logic              inter;
    logic              full;
    logic              ovf;
    logic              unf;

    modport master (
        output sBank, sAddrBank, irq_enter, irq_exit, clr,
        input  bank, level, inter, full, ovf, unf
    );

    modport slave (
        input  sBank, sAddrBank, irq_enter, irq_exit, clr,
        output bank, level, inter, full, ovf, unf
    );
endinterface

// File: rtl/bank_context_stack.sv
// bank_context_stack: per-nesting-level register bank stack with sticky overflow/underflow flags
// Optional macro BANK_INHERIT_EN: a newly entered level starts with the caller's bank instead of IRQ_BANK.
module bank_context_stack #(
    parameter int BANK_W   = 2,
    parameter int DEPTH    = 4,
    parameter int LVL_W    = 2,
    parameter int IRQ_BANK = 0,
    parameter int RST_BANK = 0
) (
    input logic clk,
    input logic rst,
    bank_context_stack_if.slave bus
);
    localparam logic [BANK_W-1:0] IRQ_VAL = BANK_W'(IRQ_BANK);
    localparam logic [BANK_W-1:0] RST_VAL = BANK_W'(RST_BANK);
    localparam logic [LVL_W-1:0]  TOP     = LVL_W'(DEPTH - 1);

    logic [BANK_W-1:0] bank_reg [DEPTH];
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  lvl_nxt;
    logic [LVL_W-1:0]  wr_idx;
    logic [BANK_W-1:0] wr_val;
    logic [BANK_W-1:0] fresh;
    logic              wr_en;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf;
    logic              unf;
    logic              at_top;
    logic              at_bot;

    assign at_top = lvl == TOP;
    assign at_bot = lvl == '0;

`ifdef BANK_INHERIT_EN
    assign fresh = bus.sBank ? bus.sAddrBank : bank_reg[lvl];
`else
    assign fresh = bus.sBank ? bus.sAddrBank : IRQ_VAL;
`endif

    // Resolve enter/exit/tail-chain/write priority into one entry write plus the next level
    always_comb begin
        lvl_nxt = lvl;
        wr_en   = 1'b0;
        wr_idx  = lvl;
        wr_val  = bus.sAddrBank;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.irq_enter && bus.irq_exit) begin
            unf_set = at_bot;
            lvl_nxt = at_bot ? LVL_W'(1) : lvl;
            wr_idx  = lvl_nxt;
            wr_val  = fresh;
            wr_en   = 1'b1;
        end else if (bus.irq_enter) begin
            ovf_set = at_top;
            lvl_nxt = at_top ? lvl : lvl + LVL_W'(1);
            wr_idx  = lvl_nxt;
            wr_val  = at_top ? bus.sAddrBank : fresh;
            wr_en   = at_top ? bus.sBank : 1'b1;
        end else if (bus.irq_exit) begin
            unf_set = at_bot;
            lvl_nxt = at_bot ? lvl : lvl - LVL_W'(1);
            wr_en   = at_bot & bus.sBank;
        end else begin
            wr_en   = bus.sBank;
        end
    end

    // Level counter, entry array and sticky flags; a set beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank_reg[i] <= RST_VAL;
        end else begin
            lvl <= lvl_nxt;
            ovf <= ovf_set | (ovf & ~bus.clr);
            unf <= unf_set | (unf & ~bus.clr);
            if (wr_en) bank_reg[wr_idx] <= wr_val;
        end
    end

    assign bus.bank  = bank_reg[lvl];
    assign bus.level = lvl;
    assign bus.inter = !at_bot;
    assign bus.full  = at_top;
    assign bus.ovf   = ovf;
    assign bus.unf   = unf;
endmodule

// File: tb/tb_bank_context_stack.sv
// tb_bank_context_stack: directed plus random stimulus against a stack-based reference model
module tb_bank_context_stack;
    localparam int BANK_W   = 2;
    localparam int DEPTH    = 4;
    localparam int LVL_W    = 2;
    localparam int IRQ_BANK = 0;
    localparam int RST_BANK = 0;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   m_lvl;
    int   m_ent [DEPTH];
    bit   m_ovf;
    bit   m_unf;

    bank_context_stack_if #(.BANK_W(BANK_W), .LVL_W(LVL_W)) bus ();

    bank_context_stack #(
        .BANK_W(BANK_W), .DEPTH(DEPTH), .LVL_W(LVL_W),
        .IRQ_BANK(IRQ_BANK), .RST_BANK(RST_BANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".bank"},  32'(bus.bank),  32'(m_ent[m_lvl]));
        chk({tag, ".level"}, 32'(bus.level), 32'(m_lvl));
        chk({tag, ".inter"}, 32'(bus.inter), 32'(m_lvl != 0));
        chk({tag, ".full"},  32'(bus.full),  32'(m_lvl == DEPTH - 1));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.unf),   32'(m_unf));
    endtask

    task automatic model_reset();
        m_lvl = 0;
        m_ovf = 0;
        m_unf = 0;
        for (int i = 0; i < DEPTH; i++) m_ent[i] = RST_BANK;
    endtask

    // Reference: treat the levels as a stack of bank numbers with a pointer.
    task automatic model_step(input bit en, input bit ex, input bit sb, input int v, input bit c);
        int caller;
        int newv;
        caller = m_ent[m_lvl];
`ifdef BANK_INHERIT_EN
        newv = sb ? v : caller;
`else
        newv = sb ? v : IRQ_BANK;
`endif
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (en && ex) begin
            if (m_lvl == 0) begin
                m_unf = 1;
                m_lvl = 1;
            end
            m_ent[m_lvl] = newv;
        end else if (en) begin
            if (m_lvl == DEPTH - 1) begin
                m_ovf = 1;
                if (sb) m_ent[m_lvl] = v;
            end else begin
                m_lvl++;
                m_ent[m_lvl] = newv;
            end
        end else if (ex) begin
            if (m_lvl == 0) begin
                m_unf = 1;
                if (sb) m_ent[0] = v;
            end else begin
                m_lvl--;
            end
        end else if (sb) begin
            m_ent[m_lvl] = v;
        end
    endtask

    task automatic step(input string tag, input bit en, input bit ex, input bit sb, input int v, input bit c);
        @(negedge clk);
        bus.irq_enter = en;
        bus.irq_exit  = ex;
        bus.sBank     = sb;
        bus.sAddrBank = BANK_W'(v);
        bus.clr       = c;
        @(posedge clk);
        #1;
        model_step(en, ex, sb, v, c);
        chk_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.irq_enter = 0;
        bus.irq_exit  = 0;
        bus.sBank     = 0;
        bus.clr       = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.irq_enter = 0;
        bus.irq_exit  = 0;
        bus.sBank     = 0;
        bus.sAddrBank = '0;
        bus.clr       = 0;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("wr3",        0, 0, 1, 3, 0);
        step("enter1",     1, 0, 0, 0, 0);
        step("wr2_l1",     0, 0, 1, 2, 0);
        step("exit1",      1'b0, 1, 0, 0, 0);
        chk("restored_bank3", 32'(bus.bank), 32'd3);

        step("enA",        1, 0, 0, 0, 0);
        step("enB",        1, 0, 0, 0, 0);
        step("enC",        1, 0, 0, 0, 0);
        chk("full_at_3", 32'(bus.full), 32'd1);
        step("en_ovf",     1, 0, 0, 0, 0);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        step("clr_ovf",    0, 0, 0, 0, 1);
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);
        step("clr_vs_ovf", 1, 0, 1, 1, 1);
        chk("ovf_wins", 32'(bus.ovf), 32'd1);

        step("ex_to2",     0, 1, 0, 0, 0);
        step("tail_l2",    1, 1, 1, 1, 0);
        chk("tail_bank1", 32'(bus.bank), 32'd1);
        step("ex_to1",     0, 1, 0, 0, 0);
        step("ex_to0",     0, 1, 0, 0, 0);
        step("unf_at0",    0, 1, 0, 0, 0);
        chk("unf_set", 32'(bus.unf), 32'd1);
        step("clr_both",   0, 0, 0, 0, 1);
        step("en_wr2",     1, 0, 1, 2, 0);
        chk("en_wr_bank2", 32'(bus.bank), 32'd2);
        step("ex_back",    0, 1, 0, 0, 0);
        step("tail_l0",    1, 1, 0, 0, 0);
        chk("tail0_level1", 32'(bus.level), 32'd1);
        step("to_l2",      1, 0, 1, 3, 0);
        async_reset("async_rst");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, (1 << BANK_W) - 1)),
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
